// File: rtl/issue_fu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_fu_scheduler
// Description : Single-issue dispatch controller. Acknowledges the head issue
//               entry when operands, the target unit, the LSU/FPU outstanding
//               budget and CSR serialisation allow it, then emits a registered
//               one-cycle valid strobe to the selected functional unit. Also
//               keeps a saturating count of cycles a valid request waited.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_fu_scheduler #(
    parameter int unsigned OUTST_W     = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    input  logic [2:0]             req_fu_i,
    input  logic                   req_ops_ready_i,
    output logic                   req_ack_o,
    input  logic                   flu_ready_i,
    input  logic                   lsu_ready_i,
    input  logic                   fpu_ready_i,
    input  logic                   lsu_done_i,
    input  logic                   fpu_done_i,
    output logic                   alu_valid_o,
    output logic                   branch_valid_o,
    output logic                   lsu_valid_o,
    output logic                   mult_valid_o,
    output logic                   fpu_valid_o,
    output logic                   csr_valid_o,
    output logic                   cvxif_valid_o,
    output logic [OUTST_W-1:0]     outstanding_o,
    output logic                   drain_o,
    input  logic                   stall_clr_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    // Functional unit encodings
    localparam logic [2:0] c_FU_NONE   = 3'd0;
    localparam logic [2:0] c_FU_ALU    = 3'd1;
    localparam logic [2:0] c_FU_BRANCH = 3'd2;
    localparam logic [2:0] c_FU_LSU    = 3'd3;
    localparam logic [2:0] c_FU_MULT   = 3'd4;
    localparam logic [2:0] c_FU_FPU    = 3'd5;
    localparam logic [2:0] c_FU_CSR    = 3'd6;
    localparam logic [2:0] c_FU_CVXIF  = 3'd7;

    // Controller states
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_DRAIN = 1'b1;

    localparam logic [OUTST_W-1:0] c_MAX_OUT = {OUTST_W{1'b1}};

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [OUTST_W-1:0]     r_outstanding;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   r_alu_valid;
    logic                   r_branch_valid;
    logic                   r_lsu_valid;
    logic                   r_mult_valid;
    logic                   r_fpu_valid;
    logic                   r_csr_valid;
    logic                   r_cvxif_valid;

    logic                   w_is_none;
    logic                   w_is_lsu;
    logic                   w_is_fpu;
    logic                   w_is_csr;
    logic                   w_unit_rdy;
    logic                   w_budget_ok;
    logic                   w_csr_ok;
    logic                   w_ack;
    logic                   w_go_drain;
    logic                   w_var_lat_acc;
    logic [OUTST_W:0]       w_out_sum;
    logic [OUTST_W:0]       w_out_dec;
    logic [OUTST_W:0]       w_out_diff;
    logic                   w_underflow;
    logic                   w_stall_inc;

    assign w_is_none = (req_fu_i == c_FU_NONE);
    assign w_is_lsu  = (req_fu_i == c_FU_LSU);
    assign w_is_fpu  = (req_fu_i == c_FU_FPU);
    assign w_is_csr  = (req_fu_i == c_FU_CSR);

    // LSU/FPU have dedicated ready signals; NONE needs no unit at all
    assign w_unit_rdy = w_is_none ? 1'b1 :
                        w_is_lsu  ? lsu_ready_i :
                        w_is_fpu  ? fpu_ready_i : flu_ready_i;

    // Variable-latency issue is blocked once the in-flight counter is full
    assign w_budget_ok = !(w_is_lsu || w_is_fpu) || (r_outstanding != c_MAX_OUT);
    // CSRs must not overtake in-flight memory/FP operations
    assign w_csr_ok    = !w_is_csr || (r_outstanding == '0);

    assign w_ack = !rst_i && (r_state == c_ST_IDLE) && req_valid_i && req_ops_ready_i
                   && w_unit_rdy && !flush_i && w_budget_ok && w_csr_ok;

    assign w_go_drain = (r_state == c_ST_IDLE) && req_valid_i && req_ops_ready_i
                        && w_is_csr && flu_ready_i && (r_outstanding != '0) && !flush_i;

    assign w_var_lat_acc = w_ack && (w_is_lsu || w_is_fpu);

    // Counter arithmetic carried one bit wider so an illegal underflow is visible
    assign w_out_sum   = {1'b0, r_outstanding} + {{OUTST_W{1'b0}}, w_var_lat_acc};
    assign w_out_dec   = {{OUTST_W{1'b0}}, lsu_done_i} + {{OUTST_W{1'b0}}, fpu_done_i};
    assign w_underflow = (w_out_sum < w_out_dec);
    assign w_out_diff  = w_underflow ? '0 : (w_out_sum - w_out_dec);

    assign w_stall_inc = req_valid_i && !w_ack && !flush_i;

    // Next-state logic: flush always returns to IDLE; DRAIN waits for zero in-flight ops
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (w_go_drain) w_state_nxt = c_ST_DRAIN;
                c_ST_DRAIN: if (r_outstanding == '0) w_state_nxt = c_ST_IDLE;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // State register and outstanding-operation counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_outstanding <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_outstanding <= '0;
            end else begin
                r_outstanding <= w_out_diff[OUTST_W-1:0];
            end
        end
    end

    // One-cycle issue strobes, one per accepted entry (NONE produces none)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alu_valid    <= 1'b0;
            r_branch_valid <= 1'b0;
            r_lsu_valid    <= 1'b0;
            r_mult_valid   <= 1'b0;
            r_fpu_valid    <= 1'b0;
            r_csr_valid    <= 1'b0;
            r_cvxif_valid  <= 1'b0;
        end else begin
            r_alu_valid    <= w_ack && (req_fu_i == c_FU_ALU);
            r_branch_valid <= w_ack && (req_fu_i == c_FU_BRANCH);
            r_lsu_valid    <= w_ack && (req_fu_i == c_FU_LSU);
            r_mult_valid   <= w_ack && (req_fu_i == c_FU_MULT);
            r_fpu_valid    <= w_ack && (req_fu_i == c_FU_FPU);
            r_csr_valid    <= w_ack && (req_fu_i == c_FU_CSR);
            r_cvxif_valid  <= w_ack && (req_fu_i == c_FU_CVXIF);
        end
    end

    // Saturating stall counter; clear wins over increment, flush leaves it alone
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (stall_clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

`ifndef SYNTHESIS
    // More completions than in-flight operations indicates an upstream bug
    always @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            assert (!w_underflow);
        end
    end
`endif

    assign req_ack_o      = w_ack;
    assign alu_valid_o    = r_alu_valid;
    assign branch_valid_o = r_branch_valid;
    assign lsu_valid_o    = r_lsu_valid;
    assign mult_valid_o   = r_mult_valid;
    assign fpu_valid_o    = r_fpu_valid;
    assign csr_valid_o    = r_csr_valid;
    assign cvxif_valid_o  = r_cvxif_valid;
    assign outstanding_o  = r_outstanding;
    assign drain_o        = (r_state == c_ST_DRAIN);
    assign stall_cnt_o    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_issue_fu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_fu_scheduler
// Description : Directed self-checking bench for issue_fu_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_fu_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        req_valid_i;
    logic [2:0]  req_fu_i;
    logic        req_ops_ready_i;
    logic        req_ack_o;
    logic        flu_ready_i;
    logic        lsu_ready_i;
    logic        fpu_ready_i;
    logic        lsu_done_i;
    logic        fpu_done_i;
    logic        alu_valid_o;
    logic        branch_valid_o;
    logic        lsu_valid_o;
    logic        mult_valid_o;
    logic        fpu_valid_o;
    logic        csr_valid_o;
    logic        cvxif_valid_o;
    logic [2:0]  outstanding_o;
    logic        drain_o;
    logic        stall_clr_i;
    logic [15:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    issue_fu_scheduler #(.OUTST_W(3), .STALL_CNT_W(16)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_fu_i        (req_fu_i),
        .req_ops_ready_i (req_ops_ready_i),
        .req_ack_o       (req_ack_o),
        .flu_ready_i     (flu_ready_i),
        .lsu_ready_i     (lsu_ready_i),
        .fpu_ready_i     (fpu_ready_i),
        .lsu_done_i      (lsu_done_i),
        .fpu_done_i      (fpu_done_i),
        .alu_valid_o     (alu_valid_o),
        .branch_valid_o  (branch_valid_o),
        .lsu_valid_o     (lsu_valid_o),
        .mult_valid_o    (mult_valid_o),
        .fpu_valid_o     (fpu_valid_o),
        .csr_valid_o     (csr_valid_o),
        .cvxif_valid_o   (cvxif_valid_o),
        .outstanding_o   (outstanding_o),
        .drain_o         (drain_o),
        .stall_clr_i     (stall_clr_i),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i         = 1'b0;
        req_valid_i     = 1'b0;
        req_fu_i        = 3'd0;
        req_ops_ready_i = 1'b1;
        flu_ready_i     = 1'b1;
        lsu_ready_i     = 1'b1;
        fpu_ready_i     = 1'b1;
        lsu_done_i      = 1'b0;
        fpu_done_i      = 1'b0;
        stall_clr_i     = 1'b0;
    endtask

    task automatic clr_stall();
        tick();
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        req_fu_i    = 3'd1;
        tick();
        #1;
        checks++;
        if (req_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %0b expected 0", req_ack_o); end
        checks++;
        if ({alu_valid_o, branch_valid_o, lsu_valid_o, mult_valid_o, fpu_valid_o, csr_valid_o, cvxif_valid_o} !== 7'd0) begin
            failures++; $display("FAIL reset_strobes: got nonzero expected 0");
        end
        checks++;
        if (outstanding_o !== 3'd0 || drain_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            failures++; $display("FAIL reset_state: got out=%0d drain=%0b stall=%0d expected 0/0/0", outstanding_o, drain_o, stall_cnt_o);
        end
        req_valid_i = 1'b0;
        #2 rst_i = 1'b0;
    endtask

    task automatic test_alu();
        idle_inputs();
        tick();
        req_valid_i = 1'b1;
        req_fu_i    = 3'd1;
        #1;
        checks++;
        if (req_ack_o !== 1'b1) begin failures++; $display("FAIL alu_ack: got %0b expected 1", req_ack_o); end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if (alu_valid_o !== 1'b1 || lsu_valid_o !== 1'b0 || csr_valid_o !== 1'b0) begin
            failures++; $display("FAIL alu_strobe: got alu=%0b lsu=%0b csr=%0b expected 1/0/0", alu_valid_o, lsu_valid_o, csr_valid_o);
        end
        tick();
        checks++;
        if (alu_valid_o !== 1'b0) begin failures++; $display("FAIL alu_strobe_off: got %0b expected 0", alu_valid_o); end
        // Four back-to-back accepts
        req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (alu_valid_o !== 1'b1) begin failures++; $display("FAIL alu_b2b_%0d: got %0b expected 1", i, alu_valid_o); end
        end
        req_valid_i = 1'b0;
        tick();
        checks++;
        if (alu_valid_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            failures++; $display("FAIL alu_b2b_end: got alu=%0b stall=%0d expected 0/0", alu_valid_o, stall_cnt_o);
        end
        // NONE is acknowledged without any strobe
        req_valid_i = 1'b1;
        req_fu_i    = 3'd0;
        #1;
        checks++;
        if (req_ack_o !== 1'b1) begin failures++; $display("FAIL none_ack: got %0b expected 1", req_ack_o); end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if ({alu_valid_o, branch_valid_o, lsu_valid_o, mult_valid_o, fpu_valid_o, csr_valid_o, cvxif_valid_o} !== 7'd0) begin
            failures++; $display("FAIL none_strobe: got nonzero expected 0");
        end
    endtask

    task automatic test_lsu_budget();
        idle_inputs();
        clr_stall();
        req_valid_i = 1'b1;
        req_fu_i    = 3'd3;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (outstanding_o !== 3'(i) || lsu_valid_o !== 1'b1) begin
                failures++; $display("FAIL lsu_fill_%0d: got out=%0d lsu=%0b expected %0d/1", i, outstanding_o, lsu_valid_o, i);
            end
        end
        #1;
        checks++;
        if (req_ack_o !== 1'b0) begin failures++; $display("FAIL lsu_budget_block: got %0b expected 0", req_ack_o); end
        tick();
        checks++;
        if (stall_cnt_o !== 16'd1 || lsu_valid_o !== 1'b0 || outstanding_o !== 3'd7) begin
            failures++; $display("FAIL lsu_budget_stall: got stall=%0d lsu=%0b out=%0d expected 1/0/7", stall_cnt_o, lsu_valid_o, outstanding_o);
        end
        lsu_done_i = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 1'b0) begin failures++; $display("FAIL lsu_done_cycle_ack: got %0b expected 0", req_ack_o); end
        tick();
        lsu_done_i = 1'b0;
        #1;
        checks++;
        if (req_ack_o !== 1'b1 || outstanding_o !== 3'd6 || stall_cnt_o !== 16'd2) begin
            failures++; $display("FAIL lsu_after_done: got ack=%0b out=%0d stall=%0d expected 1/6/2", req_ack_o, outstanding_o, stall_cnt_o);
        end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd7 || lsu_valid_o !== 1'b1) begin
            failures++; $display("FAIL lsu_8th: got out=%0d lsu=%0b expected 7/1", outstanding_o, lsu_valid_o);
        end
        lsu_done_i = 1'b1;
        repeat (7) tick();
        lsu_done_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd0) begin failures++; $display("FAIL lsu_drain_out: got %0d expected 0", outstanding_o); end
    endtask

    task automatic test_csr_drain();
        idle_inputs();
        clr_stall();
        req_valid_i = 1'b1;
        req_fu_i    = 3'd3;
        tick();
        req_fu_i    = 3'd5;
        tick();
        checks++;
        if (outstanding_o !== 3'd2 || fpu_valid_o !== 1'b1) begin
            failures++; $display("FAIL csr_setup: got out=%0d fpu=%0b expected 2/1", outstanding_o, fpu_valid_o);
        end
        req_fu_i = 3'd6;
        #1;
        checks++;
        if (req_ack_o !== 1'b0 || drain_o !== 1'b0) begin
            failures++; $display("FAIL csr_req: got ack=%0b drain=%0b expected 0/0", req_ack_o, drain_o);
        end
        tick();
        checks++;
        if (drain_o !== 1'b1 || csr_valid_o !== 1'b0) begin
            failures++; $display("FAIL csr_enter_drain: got drain=%0b csr=%0b expected 1/0", drain_o, csr_valid_o);
        end
        lsu_done_i = 1'b1;
        fpu_done_i = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 1'b0) begin failures++; $display("FAIL csr_drain_ack: got %0b expected 0", req_ack_o); end
        tick();
        lsu_done_i = 1'b0;
        fpu_done_i = 1'b0;
        #1;
        checks++;
        if (outstanding_o !== 3'd0 || drain_o !== 1'b1 || req_ack_o !== 1'b0) begin
            failures++; $display("FAIL csr_dual_done: got out=%0d drain=%0b ack=%0b expected 0/1/0", outstanding_o, drain_o, req_ack_o);
        end
        tick();
        #1;
        checks++;
        if (drain_o !== 1'b0 || req_ack_o !== 1'b1) begin
            failures++; $display("FAIL csr_exit_drain: got drain=%0b ack=%0b expected 0/1", drain_o, req_ack_o);
        end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if (csr_valid_o !== 1'b1 || stall_cnt_o !== 16'd3) begin
            failures++; $display("FAIL csr_strobe: got csr=%0b stall=%0d expected 1/3", csr_valid_o, stall_cnt_o);
        end
        tick();
        checks++;
        if (csr_valid_o !== 1'b0) begin failures++; $display("FAIL csr_strobe_off: got %0b expected 0", csr_valid_o); end
    endtask

    task automatic test_flush();
        idle_inputs();
        clr_stall();
        req_valid_i = 1'b1;
        req_fu_i    = 3'd3;
        repeat (3) tick();
        req_fu_i    = 3'd1;
        flush_i     = 1'b1;
        lsu_done_i  = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 1'b0) begin failures++; $display("FAIL flush_ack: got %0b expected 0", req_ack_o); end
        tick();
        flush_i    = 1'b0;
        lsu_done_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd0 || alu_valid_o !== 1'b0 || drain_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            failures++; $display("FAIL flush_state: got out=%0d alu=%0b drain=%0b stall=%0d expected 0/0/0/0", outstanding_o, alu_valid_o, drain_o, stall_cnt_o);
        end
        #1;
        checks++;
        if (req_ack_o !== 1'b1) begin failures++; $display("FAIL flush_resume_ack: got %0b expected 1", req_ack_o); end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if (alu_valid_o !== 1'b1) begin failures++; $display("FAIL flush_resume_strobe: got %0b expected 1", alu_valid_o); end
    endtask

    task automatic test_stall();
        idle_inputs();
        clr_stall();
        req_valid_i     = 1'b1;
        req_fu_i        = 3'd1;
        req_ops_ready_i = 1'b0;
        repeat (5) tick();
        req_ops_ready_i = 1'b1;
        #1;
        checks++;
        if (req_ack_o !== 1'b1 || stall_cnt_o !== 16'd5) begin
            failures++; $display("FAIL stall_five: got ack=%0b stall=%0d expected 1/5", req_ack_o, stall_cnt_o);
        end
        tick();
        checks++;
        if (alu_valid_o !== 1'b1 || stall_cnt_o !== 16'd5) begin
            failures++; $display("FAIL stall_issue: got alu=%0b stall=%0d expected 1/5", alu_valid_o, stall_cnt_o);
        end
        // Unit-not-ready stall also counts
        flu_ready_i = 1'b0;
        tick();
        checks++;
        if (stall_cnt_o !== 16'd6) begin failures++; $display("FAIL stall_unit: got %0d expected 6", stall_cnt_o); end
        req_ops_ready_i = 1'b0;
        repeat (65535) tick();
        checks++;
        if (stall_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL stall_saturate: got %0h expected ffff", stall_cnt_o); end
        tick();
        checks++;
        if (stall_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL stall_hold_sat: got %0h expected ffff", stall_cnt_o); end
        stall_clr_i = 1'b1;
        tick();
        stall_clr_i = 1'b0;
        checks++;
        if (stall_cnt_o !== 16'd0) begin failures++; $display("FAIL stall_clr: got %0d expected 0", stall_cnt_o); end
        tick();
        req_valid_i = 1'b0;
        checks++;
        if (stall_cnt_o !== 16'd1) begin failures++; $display("FAIL stall_after_clr: got %0d expected 1", stall_cnt_o); end
        flu_ready_i     = 1'b1;
        req_ops_ready_i = 1'b1;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        tick();
        req_valid_i = 1'b1;
        req_fu_i    = 3'd3;
        tick();
        req_fu_i = 3'd6;
        tick();
        checks++;
        if (drain_o !== 1'b1 || outstanding_o !== 3'd1) begin
            failures++; $display("FAIL areset_setup: got drain=%0b out=%0d expected 1/1", drain_o, outstanding_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (drain_o !== 1'b0 || outstanding_o !== 3'd0 || req_ack_o !== 1'b0) begin
            failures++; $display("FAIL areset_drain: got drain=%0b out=%0d ack=%0b expected 0/0/0", drain_o, outstanding_o, req_ack_o);
        end
        rst_i       = 1'b0;
        req_fu_i    = 3'd1;
        tick();
        checks++;
        if (alu_valid_o !== 1'b1) begin failures++; $display("FAIL areset_strobe_setup: got %0b expected 1", alu_valid_o); end
        req_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (alu_valid_o !== 1'b0) begin failures++; $display("FAIL areset_strobe: got %0b expected 0", alu_valid_o); end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lsu_budget();
        test_csr_drain();
        test_flush();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_fu_scheduler.md
Name: issue_fu_scheduler

Overview:
- Single-issue dispatch controller between the rename/scoreboard stage and the operand-read/functional-unit stage.
- Decides when the head issue entry may be acknowledged, based on operand readiness, per-unit readiness, an outstanding-operation budget for variable-latency units (LSU, FPU) and CSR serialisation.
- Drives registered one-cycle FU valid strobes and a saturating stall performance counter.

Parameters:
- OUTST_W, 3: width of the outstanding LSU+FPU counter; budget MAX_OUT = 2**OUTST_W-1.
- STALL_CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  synchronous pipeline flush
- req_valid_i  in  1  head issue entry valid
- req_fu_i  in  3  target unit: 0 NONE, 1 ALU, 2 BRANCH, 3 LSU, 4 MULT, 5 FPU, 6 CSR, 7 CVXIF
- req_ops_ready_i  in  1  all source operands available, rd not clobbered
- req_ack_o  out  1  entry accepted this cycle (combinational)
- flu_ready_i  in  1  fixed-latency unit ready (ALU/BRANCH/MULT/CSR/CVXIF)
- lsu_ready_i  in  1  LSU ready
- fpu_ready_i  in  1  FPU ready
- lsu_done_i  in  1  one LSU operation completed
- fpu_done_i  in  1  one FPU operation completed
- alu_valid_o, branch_valid_o, lsu_valid_o, mult_valid_o, fpu_valid_o, csr_valid_o, cvxif_valid_o  out  1 each  registered issue strobes
- outstanding_o  out  OUTST_W  in-flight LSU+FPU operation count
- drain_o  out  1  high while in DRAIN
- stall_clr_i  in  1  clear stall counter
- stall_cnt_o  out  STALL_CNT_W  cycles a valid request waited unacknowledged

Behaviour:
- Reset (rst_i high, async): state IDLE; all *_valid_o 0; outstanding_o 0; stall_cnt_o 0; req_ack_o 0 while reset is asserted.
- States: IDLE, DRAIN.
- unit_rdy: flu_ready_i for ALU/BRANCH/MULT/CSR/CVXIF; lsu_ready_i for LSU; fpu_ready_i for FPU; 1 for NONE.
- req_ack_o = IDLE & req_valid_i & req_ops_ready_i & unit_rdy & !flush_i & budget_ok & csr_ok, where:
  - budget_ok = (fu not LSU/FPU) | (outstanding_o < MAX_OUT)
  - csr_ok = (fu != CSR) | (outstanding_o == 0)
- Latency: acceptance at edge N gives exactly one matching *_valid_o high for the cycle after edge N; otherwise all strobes are 0. NONE is acknowledged with no strobe. Back-to-back acceptance is allowed, giving a strobe every cycle.
- IDLE to DRAIN: req_valid_i & req_ops_ready_i & fu==CSR & flu_ready_i & outstanding_o!=0 & !flush_i.
- DRAIN: req_ack_o=0; drain_o=1. Go to IDLE on the cycle outstanding_o becomes 0 (registered value). The CSR is acknowledged in IDLE on the following cycle if conditions hold.
- Outstanding counter, next value = cur + acc_lsu_fpu - lsu_done_i - fpu_done_i:
  - Acceptance plus one done in the same cycle leaves the value unchanged.
  - Two dones in one cycle decrement by 2.
  - Underflow is illegal; the verification assertion fires and the counter clamps at 0.
  - Overflow is prevented by budget_ok.
- Flush (flush_i high at edge):
  - req_ack_o forced 0 in that cycle.
  - All strobes 0 next cycle.
  - State to IDLE.
  - outstanding_o to 0; same-cycle done pulses are ignored.
  - stall_cnt_o is unaffected.
- Stall counter: +1 each cycle req_valid_i & !req_ack_o & !flush_i; saturates at all-ones. stall_clr_i has priority and sets 0.
- Reset mid-DRAIN or mid-strobe returns immediately to the reset values.

Test Plan:
- ALU issue: req_valid=1, fu=1, ops_ready=1, flu_ready=1 at cycle 0 -> req_ack=1 at cycle 0; alu_valid=1 at cycle 1 only; 4 consecutive requests -> 4 consecutive alu_valid pulses.
- LSU budget: with OUTST_W=3, issue 7 LSU ops with no done -> outstanding=7; 8th request ack=0 and stall_cnt increments. One lsu_done -> 8th acked next cycle; outstanding stays 7.
- CSR drain: outstanding=2, CSR request -> DRAIN, drain_o=1, ack=0. lsu_done and fpu_done in the same cycle -> outstanding 0, IDLE next cycle, CSR acked, csr_valid one cycle later.
- Flush: flush_i during an acceptable request with outstanding=3 -> ack=0, no strobe, outstanding=0, state IDLE.
- Operand/unit stall: ops_ready=0 for 5 cycles, then 1 -> stall_cnt +5, then ack. stall_cnt preset to 0xFFFF with stall -> stays 0xFFFF; stall_clr -> 0.
- Async reset asserted mid-DRAIN between clock edges -> drain_o, strobes and outstanding go 0 without waiting for a clock edge.
